// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, instruction field positions
// and the fetch-stage state type. The control unit imports the same constants.
package mips_pkg;

    localparam logic [5:0] RTYPE   = 6'b000000;
    localparam logic [5:0] SYSCALL = 6'b001100;
    localparam logic [5:0] ADD     = 6'b100000;

    // Bit positions of the instruction-word fields
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int TARGET_HI = 25;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: req/ready handshake with a word address and
// the returned instruction word.
interface instruction_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, reads instruction memory, latches the word into IR
// and presents its decoded fields until the consumer accepts it.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_if.master        mem,
    output logic                       inst_valid,
    input  logic                       inst_ack,
    input  logic                       halted,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [ADDR_W-1:0]          pc_out,
    output logic [ADDR_W-1:0]          pc_plus4,
    output logic [5:0]                 opcode,
    output logic [5:0]                 funct,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [15:0]                imm16,
    output logic [25:0]                target,
    output logic [31:0]                fetch_count,
    output logic                       is_halted
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [31:0]       ir;
    logic              capture;
    logic              accept;
    logic              mem_req_c;

    assign capture = (state == FETCH) && mem.mem_ready;
    assign accept  = (state == HOLD) && inst_ack;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: if (mem.mem_ready) state_next = HOLD;
            HOLD:  if (inst_ack)      state_next = halted ? HALT : FETCH;
            HALT:                     state_next = HALT;
            default:                  state_next = FETCH;
        endcase
    end

    // The request is held off while reset is asserted so a stale read is dropped.
    always_comb begin
        mem_req_c  = 1'b0;
        inst_valid = 1'b0;
        is_halted  = 1'b0;
        unique case (state)
            FETCH:   mem_req_c  = !reset;
            HOLD:    inst_valid = 1'b1;
            HALT:    is_halted  = 1'b1;
            default: mem_req_c  = 1'b0;
        endcase
    end

    // Redirect targets are silently word-aligned rather than faulting.
    always_comb begin
        pc_next = pc_plus4;
        if (redirect_valid) begin
            pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= PC_RESET;
            pc_out      <= PC_RESET;
            ir          <= '0;
            fetch_count <= '0;
        end else begin
            if (capture) begin
                ir     <= mem.mem_rdata;
                pc_out <= pc;
            end
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
                if (!halted) begin
                    pc <= pc_next;
                end
            end
        end
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.mem_addr = pc;
    assign pc_plus4     = pc_out + ADDR_W'(4);

    assign opcode = ir[OPCODE_HI:OPCODE_LO];
    assign rs     = ir[RS_HI:RS_LO];
    assign rt     = ir[RT_HI:RT_LO];
    assign rd     = ir[RD_HI:RD_LO];
    assign shamt  = ir[SHAMT_HI:SHAMT_LO];
    assign funct  = ir[FUNCT_HI:FUNCT_LO];
    assign imm16  = ir[IMM_HI:0];
    assign target = ir[TARGET_HI:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch against a PC/count reference model;
// a second instance checks the PC wrap from a top-of-memory reset value.
module tb_instruction_fetch;

    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset          = 1'b1;
    logic        inst_ack       = 1'b0;
    logic        halted         = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;

    instruction_fetch_if #(.ADDR_W(ADDR_W)) bus ();
    instruction_fetch_if #(.ADDR_W(ADDR_W)) bus_b ();

    logic        inst_valid, is_halted;
    logic [31:0] pc_out, pc_plus4, fetch_count;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] target;

    logic        inst_valid_b, is_halted_b;
    logic [31:0] pc_out_b, pc_plus4_b, fetch_count_b;
    logic [5:0]  opcode_b, funct_b;
    logic [4:0]  rs_b, rt_b, rd_b, shamt_b;
    logic [15:0] imm16_b;
    logic [25:0] target_b;

    instruction_fetch #(.ADDR_W(ADDR_W), .PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .mem(bus.master),
        .inst_valid(inst_valid), .inst_ack(inst_ack), .halted(halted),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16), .target(target),
        .fetch_count(fetch_count), .is_halted(is_halted)
    );

    instruction_fetch #(.ADDR_W(ADDR_W), .PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .mem(bus_b.master),
        .inst_valid(inst_valid_b), .inst_ack(inst_ack), .halted(halted),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc_out(pc_out_b), .pc_plus4(pc_plus4_b), .opcode(opcode_b), .funct(funct_b),
        .rs(rs_b), .rt(rt_b), .rd(rd_b), .shamt(shamt_b), .imm16(imm16_b), .target(target_b),
        .fetch_count(fetch_count_b), .is_halted(is_halted_b)
    );

    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_count = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        bus_b.mem_ready = 1'b0;
        bus_b.mem_rdata = '0;
        tick();
        tick();
        checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.mem_req); else passes++;
        checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else passes++;
        checks++; if (is_halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", is_halted); else passes++;
        checks++; if (fetch_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", fetch_count); else passes++;
        checks++; if ({opcode, target} !== 32'd0) $display("FAIL reset_ir: got %h want 0", {opcode, target}); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b1) $display("FAIL reset_req_rise: got %b want 1", bus.mem_req); else passes++;
        checks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.mem_addr); else passes++;
        exp_pc = 32'h0;
        exp_count = 32'h0;
    endtask

    task automatic test_sequential();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h012A_4020;
        inst_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.mem_addr !== exp_pc) $display("FAIL seq_addr: got %h want %h", bus.mem_addr, exp_pc); else passes++;
            tick();
            checks++; if (inst_valid !== 1'b1) $display("FAIL seq_valid: got %b want 1", inst_valid); else passes++;
            checks++; if ({opcode, funct, rd} !== {6'd0, 6'h20, 5'd8}) $display("FAIL seq_fields: got %h want %h", {opcode, funct, rd}, {6'd0, 6'h20, 5'd8}); else passes++;
            checks++; if ({rs, rt} !== {5'd9, 5'd10}) $display("FAIL seq_rs_rt: got %h want %h", {rs, rt}, {5'd9, 5'd10}); else passes++;
            tick();
            exp_pc = exp_pc + 32'd4;
            exp_count = exp_count + 32'd1;
        end
        bus.mem_ready = 1'b0;
        inst_ack = 1'b0;
        checks++; if (fetch_count !== 32'd3) $display("FAIL seq_count: got %0d want 3", fetch_count); else passes++;
    endtask

    task automatic test_ready_delay();
        logic [31:0] word;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({bus.mem_req, inst_valid} !== 2'b10) $display("FAIL delay_req_valid: got %b want 10", {bus.mem_req, inst_valid}); else passes++;
            checks++; if (bus.mem_addr !== exp_pc) $display("FAIL delay_addr: got %h want %h", bus.mem_addr, exp_pc); else passes++;
        end
        word = $urandom;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = word;
        tick();
        bus.mem_ready = 1'b0;
        checks++; if (inst_valid !== 1'b1) $display("FAIL delay_valid_rise: got %b want 1", inst_valid); else passes++;
        checks++; if (imm16 !== word[15:0]) $display("FAIL delay_imm: got %h want %h", imm16, word[15:0]); else passes++;
        inst_ack = 1'b1;
        tick();
        inst_ack = 1'b0;
        exp_pc = exp_pc + 32'd4;
        exp_count = exp_count + 32'd1;
    endtask

    task automatic test_redirect();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = $urandom;
        tick();
        bus.mem_ready = 1'b0;
        checks++; if (pc_out !== 32'h10) $display("FAIL redir_pc_out: got %h want 10", pc_out); else passes++;
        inst_ack = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0043;
        tick();
        inst_ack = 1'b0;
        redirect_valid = 1'b0;
        exp_pc = 32'h40;
        exp_count = exp_count + 32'd1;
        checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h40}) $display("FAIL redir_addr: got %h want %h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h40}); else passes++;
        checks++; if (fetch_count !== exp_count) $display("FAIL redir_count: got %0d want %0d", fetch_count, exp_count); else passes++;
    endtask

    task automatic test_random();
        bit          ok;
        logic [31:0] word;
        logic        take;
        logic [31:0] dest;
        for (int it = 0; it < 40; it++) begin
            wait_req(ok);
            checks++; if (ok !== 1'b1) $display("FAIL rnd_req_timeout: got %b want 1", ok); else passes++;
            checks++; if (bus.mem_addr !== exp_pc) $display("FAIL rnd_addr: got %h want %h", bus.mem_addr, exp_pc); else passes++;
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
                bus.mem_ready = 1'b0;
                inst_ack = 1'($urandom);
                halted = 1'($urandom);
                redirect_valid = 1'($urandom);
                redirect_pc = $urandom;
                tick();
                checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, exp_pc}) $display("FAIL rnd_wait: got %h want %h", {bus.mem_req, bus.mem_addr}, {1'b1, exp_pc}); else passes++;
            end
            word = $urandom;
            bus.mem_ready = 1'b1;
            bus.mem_rdata = word;
            tick();
            bus.mem_ready = 1'b0;
            checks++; if ({inst_valid, pc_out} !== {1'b1, exp_pc}) $display("FAIL rnd_valid_pc: got %h want %h", {inst_valid, pc_out}, {1'b1, exp_pc}); else passes++;
            checks++; if (pc_plus4 !== exp_pc + 32'd4) $display("FAIL rnd_pc_plus4: got %h want %h", pc_plus4, exp_pc + 32'd4); else passes++;
            checks++; if ({opcode, rs, rt, rd, shamt, funct} !== word) $display("FAIL rnd_fields: got %h want %h", {opcode, rs, rt, rd, shamt, funct}, word); else passes++;
            checks++; if ({imm16, target} !== {16'(word & 32'hFFFF), 26'(word & 32'h03FF_FFFF)}) $display("FAIL rnd_imm_target: got %h want %h", {imm16, target}, {16'(word & 32'hFFFF), 26'(word & 32'h03FF_FFFF)}); else passes++;
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                inst_ack = 1'b0;
                bus.mem_ready = 1'($urandom);
                bus.mem_rdata = $urandom;
                halted = 1'($urandom);
                redirect_valid = 1'($urandom);
                tick();
                checks++; if ({inst_valid, bus.mem_req, pc_out} !== {2'b10, exp_pc}) $display("FAIL rnd_hold: got %h want %h", {inst_valid, bus.mem_req, pc_out}, {2'b10, exp_pc}); else passes++;
            end
            take = 1'($urandom);
            dest = $urandom;
            inst_ack = 1'b1;
            halted = 1'b0;
            redirect_valid = take;
            redirect_pc = dest;
            bus.mem_ready = 1'($urandom);
            tick();
            inst_ack = 1'b0;
            redirect_valid = 1'b0;
            bus.mem_ready = 1'b0;
            exp_pc = take ? (dest & ~32'h3) : exp_pc + 32'd4;
            exp_count = exp_count + 32'd1;
            checks++; if (fetch_count !== exp_count) $display("FAIL rnd_count: got %0d want %0d", fetch_count, exp_count); else passes++;
        end
    endtask

    task automatic test_halt();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_000C;
        tick();
        bus.mem_ready = 1'b0;
        inst_ack = 1'b1;
        halted = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        halted = 1'b0;
        exp_count = exp_count + 32'd1;
        checks++; if (fetch_count !== exp_count) $display("FAIL halt_count: got %0d want %0d", fetch_count, exp_count); else passes++;
        for (int i = 0; i < 20; i++) begin
            checks++; if ({bus.mem_req, inst_valid, is_halted} !== 3'b001) $display("FAIL halt_state: got %b want 001", {bus.mem_req, inst_valid, is_halted}); else passes++;
            checks++; if (funct !== 6'h0C) $display("FAIL halt_funct: got %h want 0c", funct); else passes++;
            bus.mem_ready = 1'($urandom);
            inst_ack = 1'($urandom);
            redirect_valid = 1'($urandom);
            tick();
        end
        bus.mem_ready = 1'b0;
        inst_ack = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pc = 32'h0;
        for (int i = 0; i < 9; i++) begin
            bus.mem_ready = 1'b1;
            tick();
            bus.mem_ready = 1'b0;
            inst_ack = 1'b1;
            tick();
            inst_ack = 1'b0;
            exp_pc = exp_pc + 32'd4;
        end
        tick();
        tick();
        checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h24}) $display("FAIL mid_wait: got %h want %h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h24}); else passes++;
        reset = 1'b1;
        #1;
        checks++; if ({bus.mem_req, inst_valid} !== 2'b00) $display("FAIL mid_reset_cycle: got %b want 00", {bus.mem_req, inst_valid}); else passes++;
        tick();
        reset = 1'b0;
        #1;
        checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0}) $display("FAIL mid_restart: got %h want %h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h0}); else passes++;
        checks++; if ({inst_valid, fetch_count} !== 33'd0) $display("FAIL mid_cleared: got %h want 0", {inst_valid, fetch_count}); else passes++;
    endtask

    task automatic test_pc_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if ({bus_b.mem_req, bus_b.mem_addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_first_addr: got %h want %h", {bus_b.mem_req, bus_b.mem_addr}, {1'b1, 32'hFFFF_FFFC}); else passes++;
        bus_b.mem_ready = 1'b1;
        bus_b.mem_rdata = $urandom;
        tick();
        bus_b.mem_ready = 1'b0;
        checks++; if (pc_out_b !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_out: got %h want fffffffc", pc_out_b); else passes++;
        checks++; if (pc_plus4_b !== 32'h0) $display("FAIL wrap_pc_plus4: got %h want 0", pc_plus4_b); else passes++;
        inst_ack = 1'b1;
        tick();
        inst_ack = 1'b0;
        checks++; if ({bus_b.mem_req, bus_b.mem_addr} !== {1'b1, 32'h0}) $display("FAIL wrap_next_addr: got %h want %h", {bus_b.mem_req, bus_b.mem_addr}, {1'b1, 32'h0}); else passes++;
        checks++; if (fetch_count_b !== 32'd1) $display("FAIL wrap_count: got %0d want 1", fetch_count_b); else passes++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ready_delay();
        test_redirect();
        test_random();
        test_halt();
        test_reset_mid_fetch();
        test_pc_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Upstream neighbour of the control unit (CU).
- Holds the PC and issues word reads to instruction memory over a req/ready handshake.
- Latches the returned word into an instruction register (IR) and presents the decoded fields (opcode, funct, rs, rt, rd, shamt, imm16, target) to CU and the datapath.
- Honours branch/jump redirects and freezes permanently once CU reports halted.

Parameters:
ADDR_W, 32, PC/address width in bits
PC_RESET, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
mem_req  output  1  instruction read request
mem_addr  output  ADDR_W  word-aligned read address
mem_ready  input  1  read data valid this cycle
mem_rdata  input  32  instruction word
inst_valid  output  1  IR holds a valid instruction
inst_ack  input  1  consumer accepts IR this cycle
halted  input  1  from CU; SYSCALL decoded
redirect_valid  input  1  branch/jump taken
redirect_pc  input  ADDR_W  redirect target
pc_out  output  ADDR_W  address of instruction in IR
pc_plus4  output  ADDR_W  pc_out + 4, for link/branch base
opcode  output  6  IR[31:26]
funct  output  6  IR[5:0]
rs / rt / rd  output  5 each  IR[25:21] / IR[20:16] / IR[15:11]
shamt  output  5  IR[10:6]
imm16  output  16  IR[15:0]
target  output  26  IR[25:0]
fetch_count  output  32  instructions accepted since reset
is_halted  output  1  HALT state reached

Behaviour:
- Reset values: state=FETCH, pc=PC_RESET, IR=0, inst_valid=0, fetch_count=0, is_halted=0.
- mem_req is low in the reset cycle and rises the following cycle.
- State FETCH:
  - mem_req=1 and mem_addr=pc, both decoded from registered state.
  - mem_req stays high until mem_ready; the address is stable while waiting.
  - On mem_ready: IR<=mem_rdata, pc_out<=pc, inst_valid<=1, state->HOLD.
  - Minimum latency: ready in the first request cycle gives inst_valid on the next edge.
- State HOLD:
  - mem_req=0; IR and the field outputs are stable; inst_valid=1.
  - Without inst_ack, stay in HOLD indefinitely.
  - On inst_ack: fetch_count += 1 (wraps at 2^32); inst_valid<=0.
  - Priority on the inst_ack cycle is halted > redirect_valid > sequential:
    - halted=1: state->HALT.
    - else redirect_valid=1: pc<={redirect_pc[ADDR_W-1:2],2'b00} (low bits forced to zero, no fault), state->FETCH.
    - else: pc<=pc_out+4, state->FETCH.
- State HALT:
  - mem_req=0, inst_valid=0, is_halted=1; IR keeps the SYSCALL word.
  - Only reset leaves HALT.
- Sampling rules:
  - redirect_valid and halted are sampled only on a HOLD cycle with inst_ack=1; they are ignored otherwise.
  - mem_ready outside FETCH is ignored.
- Arithmetic: pc+4 is modulo 2^ADDR_W (0xFFFF_FFFC -> 0x0000_0000). pc_plus4 = pc_out+4, combinational.
- Field outputs are pure slices of the registered IR; no combinational path from mem_rdata.
- Reset mid-request: state returns to FETCH with pc=PC_RESET. The memory sees mem_req low for one cycle and must drop the stale read.
- Back-to-back throughput: one instruction per 2 cycles minimum (FETCH+HOLD); no prefetch.

Decomposition:
- Shared package mips_pkg holds:
  - opcode/funct localparams (RTYPE=6'b000000, SYSCALL=6'b001100, ADD=6'b100000);
  - IR field bit positions;
  - typedef enum fetch_state_t {FETCH, HOLD, HALT}.
- CU imports mips_pkg for the same opcode constants.
- Single module; no sub-module is warranted. The PC register and next-PC mux stay inline.

Test Plan:
1. Reset, mem_ready=1 every cycle, mem_rdata=ADD word 32'h012A_4020, inst_ack=1 in HOLD -> mem_addr sequence 0,4,8; opcode=0, funct=6'h20, rd=8; fetch_count=3 after three accepts.
2. mem_ready delayed 5 cycles -> mem_req held high and mem_addr stable for all 5 cycles; inst_valid rises exactly one edge after mem_ready.
3. Instruction at 0x10 accepted with redirect_valid=1, redirect_pc=0x0000_0043 -> next mem_addr=0x0000_0040.
4. SYSCALL word 32'h0000_000C accepted with halted=1 and redirect_valid=1 -> HALT; redirect ignored, mem_req=0 for 20 cycles, is_halted=1, funct stays 6'h0C.
5. PC_RESET=32'hFFFF_FFFC, one sequential accept -> next mem_addr=0x0000_0000; pc_plus4 of the first instruction = 0.
6. reset asserted during a FETCH wait at pc=0x24 -> mem_req=0 in the reset cycle, inst_valid=0, then the fetch restarts at PC_RESET.
